// File: rtl/operand_fetch_16.sv
// operand_fetch_16
// Register file plus operand latch for the 16-bit MIPS datapath.
// Holds NREG general-purpose registers. r0 is hardwired to zero.
// Two source operands are read every cycle and registered into op_a/op_b.
// A same-cycle write-back is bypassed onto the read path.
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset (clears registers and latch)
//   rd_en     load the operand latch this cycle
//   rs, rt    source register addresses for operands A and B
//   stall     hold the operand latch (register writes still happen)
//   flush     invalidate and zero the operand latch (beats stall and rd_en)
//   we/wa/wd  write-back enable, address and data
//   op_a/op_b registered operands to the ALU
//   op_valid  op_a/op_b hold a valid pair
//   busy_a/b  combinational: rs/rt matches the in-flight write (never r0)
module operand_fetch_16 #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_en,
    input  logic [AW-1:0]    rs,
    input  logic [AW-1:0]    rt,
    input  logic             stall,
    input  logic             flush,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             op_valid,
    output logic             busy_a,
    output logic             busy_b
);

    logic [WIDTH-1:0] reg_q [NREG];
    logic [WIDTH-1:0] reg_d [NREG];

    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_valid_q, op_valid_d;

    logic             wr_live;
    logic [WIDTH-1:0] rd_a;
    logic [WIDTH-1:0] rd_b;

    // A write to r0 is treated as no write at all, both for storage and
    // for the bypass / busy paths.
    assign wr_live = we && (wa != '0);

    always_comb begin
        rd_a = reg_q[rs];
        if (rs == '0) begin
            rd_a = '0;
        end else if (wr_live && (wa == rs)) begin
            rd_a = wd;
        end
    end

    always_comb begin
        rd_b = reg_q[rt];
        if (rt == '0) begin
            rd_b = '0;
        end else if (wr_live && (wa == rt)) begin
            rd_b = wd;
        end
    end

    assign busy_a = wr_live && (wa == rs);
    assign busy_b = wr_live && (wa == rt);

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            reg_d[i] = reg_q[i];
        end
        if (wr_live) begin
            reg_d[wa] = wd;
        end
        // r0 stays zero regardless of what the write path produced.
        reg_d[0] = '0;
    end

    always_comb begin
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        if (flush) begin
            op_a_d     = '0;
            op_b_d     = '0;
            op_valid_d = 1'b0;
        end else if (stall) begin
            op_valid_d = op_valid_q;
        end else if (rd_en) begin
            op_a_d     = rd_a;
            op_b_d     = rd_b;
            op_valid_d = 1'b1;
        end else begin
            // Data is left as-is; consumers ignore it while op_valid is low.
            op_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= '0;
            end
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= reg_d[i];
            end
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_valid = op_valid_q;

endmodule

// File: tb/tb_operand_fetch_16.sv
// tb_operand_fetch_16
// Scoreboard bench: each driven cycle pushes the expected latch contents,
// which are popped and compared one clock later.
module tb_operand_fetch_16;

    logic        clk;
    logic        reset_n;
    logic        rd_en;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        stall;
    logic        flush;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_valid;
    logic        busy_a;
    logic        busy_b;

    operand_fetch_16 #(.WIDTH(16), .NREG(8), .AW(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_en    (rd_en),
        .rs       (rs),
        .rt       (rt),
        .stall    (stall),
        .flush    (flush),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_valid (op_valid),
        .busy_a   (busy_a),
        .busy_b   (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        v;
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] m_reg [8];
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic        m_v;
    logic        bsy_a_s;
    logic        bsy_b_s;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
        m_a = 16'h0;
        m_b = 16'h0;
        m_v = 1'b0;
    endtask

    // One clock: drive at negedge, check busy, push expectation,
    // then pop and compare #1 after the rising edge.
    task automatic cycle(input logic re, input logic [2:0] s, input logic [2:0] t,
                         input logic st, input logic fl, input logic w,
                         input logic [2:0] a, input logic [15:0] d);
        logic [15:0] ra, rb;
        logic        wl;
        exp_t        e;
        @(negedge clk);
        rd_en = re; rs = s; rt = t; stall = st; flush = fl;
        we = w; wa = a; wd = d;
        wl = w && (a != 3'd0);
        ra = (s == 3'd0) ? 16'h0 : ((wl && a == s) ? d : m_reg[s]);
        rb = (t == 3'd0) ? 16'h0 : ((wl && a == t) ? d : m_reg[t]);
        #1;
        bsy_a_s = busy_a;
        bsy_b_s = busy_b;
        chk("busy_a", {31'b0, busy_a}, {31'b0, wl && (a == s)});
        chk("busy_b", {31'b0, busy_b}, {31'b0, wl && (a == t)});
        if (fl) begin
            m_a = 16'h0; m_b = 16'h0; m_v = 1'b0;
        end else if (!st) begin
            if (re) begin
                m_a = ra; m_b = rb; m_v = 1'b1;
            end else begin
                m_v = 1'b0;
            end
        end
        if (wl) m_reg[a] = d;
        exp_q.push_back('{a: m_a, b: m_b, v: m_v});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk("op_a", {16'b0, op_a}, {16'b0, e.a});
            chk("op_b", {16'b0, op_b}, {16'b0, e.b});
            chk("op_valid", {31'b0, op_valid}, {31'b0, e.v});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        reset_n = 1'b0;
        rd_en = 0; rs = 0; rt = 0; stall = 0; flush = 0; we = 0; wa = 0; wd = 0;
        #12;
        chk("rst_a", {16'b0, op_a}, 32'h0);
        chk("rst_b", {16'b0, op_b}, 32'h0);
        chk("rst_v", {31'b0, op_valid}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // fetch of never-written registers
        cycle(1, 3'd3, 3'd5, 0, 0, 0, 3'd0, 16'h0);
        chk("tp1_a", {16'b0, op_a}, 32'h0000);
        chk("tp1_v", {31'b0, op_valid}, 32'h1);

        // write then read
        cycle(0, 3'd0, 3'd0, 0, 0, 1, 3'd2, 16'hA5A5);
        cycle(1, 3'd2, 3'd0, 0, 0, 0, 3'd0, 16'h0);
        chk("tp2_a", {16'b0, op_a}, 32'hA5A5);
        chk("tp2_b", {16'b0, op_b}, 32'h0000);

        // same-cycle bypass on both operands
        cycle(1, 3'd4, 3'd4, 0, 0, 1, 3'd4, 16'h1234);
        chk("tp3_busy_a", {31'b0, bsy_a_s}, 32'h1);
        chk("tp3_busy_b", {31'b0, bsy_b_s}, 32'h1);
        chk("tp3_a", {16'b0, op_a}, 32'h1234);
        chk("tp3_b", {16'b0, op_b}, 32'h1234);

        // write to r0 is ignored
        cycle(1, 3'd0, 3'd0, 0, 0, 1, 3'd0, 16'hFFFF);
        chk("tp4_busy_a", {31'b0, bsy_a_s}, 32'h0);
        cycle(1, 3'd0, 3'd0, 0, 0, 0, 3'd0, 16'h0);
        chk("tp4_a", {16'b0, op_a}, 32'h0000);

        // stall holds while the register file keeps writing
        cycle(0, 3'd0, 3'd0, 0, 0, 1, 3'd3, 16'h00F0);
        cycle(1, 3'd3, 3'd2, 0, 0, 0, 3'd0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 3'd1, 3'd1, 1, 0, 1, 3'd1, 16'h0F0F);
            chk("tp5_a", {16'b0, op_a}, 32'h00F0);
            chk("tp5_v", {31'b0, op_valid}, 32'h1);
        end
        cycle(1, 3'd1, 3'd1, 1, 1, 0, 3'd0, 16'h0);
        chk("tp5_flush_v", {31'b0, op_valid}, 32'h0);
        chk("tp5_flush_a", {16'b0, op_a}, 32'h0000);
        cycle(1, 3'd1, 3'd2, 0, 0, 0, 3'd0, 16'h0);
        chk("tp5_r1", {16'b0, op_a}, 32'h0F0F);
        cycle(0, 3'd3, 3'd3, 0, 0, 0, 3'd0, 16'h0);
        chk("idle_v", {31'b0, op_valid}, 32'h0);
        chk("idle_hold", {16'b0, op_a}, 32'h0F0F);

        // randomized traffic against the model
        for (int i = 0; i < 60; i++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1) == 1, 3'($urandom), 16'($urandom));
        end

        // asynchronous reset between edges
        cycle(0, 3'd0, 3'd0, 0, 0, 1, 3'd6, 16'hBEEF);
        cycle(1, 3'd6, 3'd6, 0, 0, 0, 3'd0, 16'h0);
        chk("tp6_pre", {16'b0, op_a}, 32'hBEEF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("tp6_async_a", {16'b0, op_a}, 32'h0);
        chk("tp6_async_b", {16'b0, op_b}, 32'h0);
        chk("tp6_async_v", {31'b0, op_valid}, 32'h0);
        model_reset();
        #1;
        reset_n = 1'b1;
        cycle(1, 3'd6, 3'd6, 0, 0, 0, 3'd0, 16'h0);
        chk("tp6_r6", {16'b0, op_a}, 32'h0000);
        chk("tp6_v", {31'b0, op_valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
